gnrl_pkt_rr_arb: RTL and testbench
==================================

Name: gnrl_pkt_rr_arb

Overview:
- Packet-granular round-robin arbiter that shares one registered valid/ready output stream among N requesters, such as ingress ports feeding a shared switch buffer or queue writer.
- Once a requester wins, it owns the output until its end-of-packet (eop) beat has transferred. Beats are never interleaved between sources.
- The output is a one-deep valid/ready register stage, optionally with a skid stage that registers the ready path.
- Sits between per-port ingress logic and the shared downstream datapath.

Parameters:
- N, 4: number of requesters. Legal values 2..16.
- DW, 32: data width per beat.
- SW, $clog2(N): width of the source index. Derived; do not override.
- CUT_RDY, 0: 1 inserts a skid stage so ready is registered; 0 gives a plain register stage.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  asynchronous reset, active-low.
- din_i  in  N*DW  requester data; slice k is [k*DW +: DW].
- din_vld_i  in  N  per-requester beat valid.
- din_eop_i  in  N  per-requester last beat of packet; qualified by din_vld_i[k].
- din_rdy_o  out  N  per-requester ready; at most one bit set in any cycle.
- dout_o  out  DW  arbitrated data, registered.
- dout_eop_o  out  1  eop of the output beat, registered.
- dout_src_o  out  SW  index of the requester that supplied the output beat, registered.
- dout_vld_o  out  1  output valid, registered.
- dout_rdy_i  in  1  downstream ready.

Behaviour:
- Transfer rule: a beat transfers on any interface when vld and rdy are both high at a clk_i edge. Once vld is asserted, the requester holds vld, data and eop stable until the beat transfers.
- stg_rdy is the ready of the output stage:
  - CUT_RDY=0: stg_rdy = !dout_vld_o || dout_rdy_i.
  - CUT_RDY=1: stg_rdy is the registered skid-buffer ready.
- FSM has two states, IDLE and LOCK. Arbitration state is ptr_q (SW bits, highest-priority index) and own_q (SW bits, locked owner).
- IDLE:
  - grant = first k with din_vld_i[k]=1, scanning ptr_q, ptr_q+1, … modulo N.
  - din_rdy_o[grant] = stg_rdy; all other bits are 0. If no request is valid, din_rdy_o = 0.
  - On transfer: ptr_q <= (grant+1) mod N. If din_eop_i[grant]=0: own_q <= grant and state goes to LOCK. If eop=1 (single-beat packet): stay in IDLE.
- LOCK:
  - din_rdy_o[own_q] = stg_rdy; all other bits are 0. Other requesters' valids are ignored.
  - On a transfer with din_eop_i[own_q]=1: go to IDLE.
- No bubble between packets: if eop transfers at cycle t, the next packet's first beat can be granted and transferred at t+1.
- Grant and din_rdy_o are combinational from registered state and din_vld_i; they never depend combinationally on dout_rdy_i when CUT_RDY=1.
- Output stage is a single register. Latency is 1 cycle from input transfer to dout_vld_o.
  - On transfer: dout_o, dout_eop_o and dout_src_o load from the selected source, and dout_vld_o <= 1.
  - When stg_rdy=1 and there is no input transfer: dout_vld_o <= 0.
  - Otherwise hold all outputs.
- Full throughput: one beat per cycle while dout_rdy_i=1.
- Back-pressure: dout_rdy_i=0 with dout_vld_o=1 forces din_rdy_o=0 (CUT_RDY=0). Output data holds stable while back-pressured.
- Requester dropping vld mid-packet while in LOCK: stay in LOCK, din_rdy_o stays offered, and no other port is served (no timeout).
- Reset values (asynchronous reset, any time including mid-packet): state=IDLE, ptr_q=0, own_q=0, dout_o=0, dout_eop_o=0, dout_src_o=0, dout_vld_o=0, din_rdy_o=0 while rst_n_i=0. Any partial packet is discarded; upstream is responsible for restarting.

Decomposition:
- Shared constants/header: the clog2 helper and the requester-index width convention, reused by other switch arbiters.
- Sub-module rr_pri_sel: purely combinational round-robin first-one selector (req[N], ptr[SW] -> gnt_oh[N], gnt_idx[SW], any).
- Output stage: instance of the existing gnrl_buf with DW+1+SW width (data, eop and source packed), passing CUT_RDY through. stg_rdy is its din_rdy_o.

Test Plan:
- Reset, then N=4 with only port 2 sending a 3-beat packet (A0,A1,A2 with eop on A2) and dout_rdy_i=1: dout shows A0..A2 on consecutive cycles, 1 cycle after input, dout_src_o=2, eop only on A2; ptr_q=3 afterwards.
- All 4 ports continuously valid with 2-beat packets, starting from ptr_q=0: packets are granted in order 0,1,2,3,0; there are no dead cycles and no interleaving; din_rdy_o is one-hot or zero every cycle.
- Port 1 sends 4 beats while dout_rdy_i toggles 1,0,0,1,… and port 3 raises a request mid-packet: port 3 gets no ready until port 1's eop transfers; output beats are neither lost nor duplicated and data holds during stalls.
- Single-beat packets (eop=1 on every beat) from ports 0 and 3 requesting together: output alternates src 0,3,0,3 and the FSM never enters LOCK.
- Assert rst_n_i mid-packet (port 2, beat 2 of 5, dout_vld_o=1): dout_vld_o and din_rdy_o go to 0 immediately; after release, state=IDLE, ptr_q=0, and a fresh request from port 0 is granted first.
- Repeat the throughput and back-pressure scenarios with CUT_RDY=1: same output sequence, full throughput when dout_rdy_i=1, and no combinational path from dout_rdy_i to din_rdy_o.

Source files
------------

// File: rtl/gnrl_pkt_rr_arb_pkg.sv
// Shared definitions for the switch arbiters: requester index width helper and arbiter FSM encoding.
package gnrl_pkt_rr_arb_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;

    // A lone requester still needs a one-bit index so port widths never collapse to zero.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/gnrl_buf.sv
// One-deep valid/ready register stage; CUT_RDY=1 adds a skid entry so din_rdy_o comes straight from a flop.
module gnrl_buf #(
    parameter int DW      = 32,
    parameter bit CUT_RDY = 1'b0
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic [DW-1:0] din_i,
    input  logic          din_vld_i,
    output logic          din_rdy_o,
    output logic [DW-1:0] dout_o,
    output logic          dout_vld_o,
    input  logic          dout_rdy_i
);

    logic [DW-1:0] dat_q, dat_d;
    logic          vld_q, vld_d;
    logic          out_free;

    assign out_free   = !vld_q || dout_rdy_i;
    assign dout_o     = dat_q;
    assign dout_vld_o = vld_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            dat_q <= '0;
            vld_q <= 1'b0;
        end else begin
            dat_q <= dat_d;
            vld_q <= vld_d;
        end
    end

    if (CUT_RDY) begin : g_skid
        logic [DW-1:0] skd_q, skd_d;
        logic          skd_vld_q, skd_vld_d;
        logic          in_xfer;

        assign din_rdy_o = !skd_vld_q;
        assign in_xfer   = din_vld_i && !skd_vld_q;

        // A parked skid beat drains into the output register before any new beat is accepted.
        always_comb begin
            dat_d     = dat_q;
            vld_d     = vld_q;
            skd_d     = skd_q;
            skd_vld_d = skd_vld_q;
            if (out_free) begin
                if (skd_vld_q) begin
                    dat_d     = skd_q;
                    vld_d     = 1'b1;
                    skd_vld_d = 1'b0;
                end else begin
                    vld_d = in_xfer;
                    if (in_xfer) begin
                        dat_d = din_i;
                    end
                end
            end else if (in_xfer) begin
                skd_d     = din_i;
                skd_vld_d = 1'b1;
            end
        end

        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                skd_q     <= '0;
                skd_vld_q <= 1'b0;
            end else begin
                skd_q     <= skd_d;
                skd_vld_q <= skd_vld_d;
            end
        end
    end else begin : g_plain
        assign din_rdy_o = out_free;

        always_comb begin
            dat_d = dat_q;
            vld_d = vld_q;
            if (out_free) begin
                vld_d = din_vld_i;
                if (din_vld_i) begin
                    dat_d = din_i;
                end
            end
        end
    end

endmodule

// File: rtl/gnrl_pkt_rr_arb_rr_pri_sel.sv
// Combinational round-robin first-one selector: lowest-distance requester at or after ptr_i, modulo N.
module rr_pri_sel
    import gnrl_pkt_rr_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int SW = idx_w(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [SW-1:0] ptr_i,
    output logic [N-1:0]  gnt_oh_o,
    output logic [SW-1:0] gnt_idx_o,
    output logic          any_o
);

    logic [SW-1:0] idx;

    // Wrap explicitly at N-1 so a non-power-of-two N never walks past the last requester.
    always_comb begin
        gnt_idx_o = '0;
        any_o     = 1'b0;
        idx       = ptr_i;
        for (int i = 0; i < N; i++) begin
            if (!any_o && req_i[idx]) begin
                any_o     = 1'b1;
                gnt_idx_o = idx;
            end
            idx = (idx == SW'(N - 1)) ? '0 : idx + 1'b1;
        end
    end

    assign gnt_oh_o = any_o ? (N'(1) << gnt_idx_o) : '0;

endmodule

// File: rtl/gnrl_pkt_rr_arb.sv
// Packet-granular round-robin arbiter: the winning requester owns the registered output stream until its eop beat transfers.
module gnrl_pkt_rr_arb
    import gnrl_pkt_rr_arb_pkg::*;
#(
    parameter int N       = 4,
    parameter int DW      = 32,
    parameter int SW      = idx_w(N),
    parameter bit CUT_RDY = 1'b0
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic [N*DW-1:0] din_i,
    input  logic [N-1:0]    din_vld_i,
    input  logic [N-1:0]    din_eop_i,
    output logic [N-1:0]    din_rdy_o,
    output logic [DW-1:0]   dout_o,
    output logic            dout_eop_o,
    output logic [SW-1:0]   dout_src_o,
    output logic            dout_vld_o,
    input  logic            dout_rdy_i
);

    localparam int BW = DW + 1 + SW;

    logic [0:0]    state_q, state_d;
    logic [SW-1:0] ptr_q, ptr_d;
    logic [SW-1:0] own_q, own_d;
    logic [N-1:0]  gnt_oh;
    logic [SW-1:0] gnt_idx;
    logic          gnt_any;
    logic          locked;
    logic [SW-1:0] sel_idx;
    logic          sel_vld;
    logic          sel_eop;
    logic [DW-1:0] sel_dat;
    logic [N-1:0]  rdy_oh;
    logic          stg_rdy;
    logic          xfer;
    logic [BW-1:0] buf_dout;

    rr_pri_sel #(
        .N  (N),
        .SW (SW)
    ) u_sel (
        .req_i     (din_vld_i),
        .ptr_i     (ptr_q),
        .gnt_oh_o  (gnt_oh),
        .gnt_idx_o (gnt_idx),
        .any_o     (gnt_any)
    );

    assign locked  = (state_q == ST_LOCK);
    assign sel_idx = locked ? own_q : gnt_idx;
    assign sel_vld = locked ? din_vld_i[own_q] : gnt_any;
    assign rdy_oh  = locked ? (N'(1) << own_q) : gnt_oh;
    assign xfer    = sel_vld && stg_rdy;

    // The output stage looks free while held in reset, so reset masks ready explicitly.
    assign din_rdy_o = (rst_n_i && stg_rdy) ? rdy_oh : '0;

    always_comb begin
        sel_dat = '0;
        sel_eop = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (sel_idx == SW'(k)) begin
                sel_dat = din_i[k*DW +: DW];
                sel_eop = din_eop_i[k];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        own_d   = own_q;
        if (xfer) begin
            if (!locked) begin
                ptr_d = (gnt_idx == SW'(N - 1)) ? '0 : gnt_idx + 1'b1;
                if (!sel_eop) begin
                    own_d   = gnt_idx;
                    state_d = ST_LOCK;
                end
            end else if (sel_eop) begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            own_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            own_q   <= own_d;
        end
    end

    gnrl_buf #(
        .DW      (BW),
        .CUT_RDY (CUT_RDY)
    ) u_out (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .din_i      ({sel_eop, sel_idx, sel_dat}),
        .din_vld_i  (sel_vld),
        .din_rdy_o  (stg_rdy),
        .dout_o     (buf_dout),
        .dout_vld_o (dout_vld_o),
        .dout_rdy_i (dout_rdy_i)
    );

    assign {dout_eop_o, dout_src_o, dout_o} = buf_dout;

endmodule

// File: tb/tb_gnrl_pkt_rr_arb.sv
// Scoreboard bench: one arbiter per CUT_RDY setting fed identical packets, checked against a packet-level reference model.
module tb_gnrl_pkt_rr_arb;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int SW = 2;
    localparam int NI = 2;

    typedef struct packed {
        logic          eop;
        logic [DW-1:0] data;
    } beat_t;

    typedef struct packed {
        logic          eop;
        logic [SW-1:0] src;
        logic [DW-1:0] data;
    } obeat_t;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    logic [N*DW-1:0] din     [NI];
    logic [N-1:0]    dinVld  [NI];
    logic [N-1:0]    dinEop  [NI];
    logic [N-1:0]    dinRdy  [NI];
    logic [DW-1:0]   dout    [NI];
    logic            doutEop [NI];
    logic [SW-1:0]   doutSrc [NI];
    logic            doutVld [NI];
    logic            doutRdy [NI];

    beat_t  portQ [NI][N][$];
    obeat_t expQ  [NI][$];

    int checks  = 0;
    int errors  = 0;
    int rdyMode = 0;
    int gapPct  = 0;

    task automatic checkOutput(input string name, input int inst, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s (cut_rdy=%0d) at %0t: got %0h, expected %0h", name, inst, $time, act, exp);
        end
    endtask

    // Queue one packet of len beats on a port of every DUT; eop marks the final beat.
    task automatic applyStimulus(input int port, input int len);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data = $urandom;
            b.eop  = (i == len - 1);
            for (int g = 0; g < NI; g++) begin
                portQ[g][port].push_back(b);
            end
        end
    endtask

    task automatic waitDrain(input int maxCycles);
        int  n;
        bit  busy;
        n = 0;
        do begin
            @(negedge clk);
            #2;
            busy = 1'b0;
            for (int g = 0; g < NI; g++) begin
                if (expQ[g].size() != 0 || doutVld[g]) busy = 1'b1;
                for (int k = 0; k < N; k++) begin
                    if (portQ[g][k].size() != 0) busy = 1'b1;
                end
            end
            n++;
        end while (busy && n < maxCycles);
        checkOutput("drain_timeout", 0, 64'(busy), 64'd0);
    endtask

    for (genvar g = 0; g < NI; g++) begin : g_dut
        int ptrM;
        int ownM;
        int cntM;
        int rdyCyc;

        gnrl_pkt_rr_arb #(
            .N       (N),
            .DW      (DW),
            .CUT_RDY (1'(g))
        ) u_dut (
            .clk_i      (clk),
            .rst_n_i    (rst_n),
            .din_i      (din[g]),
            .din_vld_i  (dinVld[g]),
            .din_eop_i  (dinEop[g]),
            .din_rdy_o  (dinRdy[g]),
            .dout_o     (dout[g]),
            .dout_eop_o (doutEop[g]),
            .dout_src_o (doutSrc[g]),
            .dout_vld_o (doutVld[g]),
            .dout_rdy_i (doutRdy[g])
        );

        // Requesters plus reference model: output stage seen as a FIFO of depth 1 (plain) or 2 (skid).
        initial begin : driver
            int          sel;
            logic        stgRdyM;
            logic        inM;
            logic        outM;
            logic [N-1:0] expRdy;
            logic [N-1:0] act;
            obeat_t      o;
            din[g]     = '0;
            dinVld[g]  = '0;
            dinEop[g]  = '0;
            doutRdy[g] = 1'b0;
            ptrM   = 0;
            ownM   = -1;
            cntM   = 0;
            rdyCyc = 0;
            forever begin
                @(negedge clk);
                act = '0;
                if (!rst_n) begin
                    ptrM = 0;
                    ownM = -1;
                    cntM = 0;
                    expQ[g].delete();
                    for (int k = 0; k < N; k++) portQ[g][k].delete();
                    checkOutput("rst_din_rdy", g, 64'(dinRdy[g]), 64'd0);
                    checkOutput("rst_dout_vld", g, 64'(doutVld[g]), 64'd0);
                    checkOutput("rst_dout_beat", g, 64'({doutEop[g], doutSrc[g], dout[g]}), 64'd0);
                end else begin
                    sel = -1;
                    if (ownM >= 0) begin
                        sel = ownM;
                    end else begin
                        for (int i = 0; i < N; i++) begin
                            if (sel < 0 && dinVld[g][(ptrM + i) % N]) sel = (ptrM + i) % N;
                        end
                    end
                    stgRdyM = (g == 0) ? (cntM == 0 || doutRdy[g]) : (cntM < 2);
                    expRdy  = (sel >= 0 && stgRdyM) ? (N'(1) << sel) : '0;
                    checkOutput("din_rdy", g, 64'(dinRdy[g]), 64'(expRdy));
                    checkOutput("rdy_onehot0", g, 64'($onehot0(dinRdy[g])), 64'd1);
                    checkOutput("dout_vld", g, 64'(doutVld[g]), 64'(cntM > 0));
                    inM  = (sel >= 0) && stgRdyM && dinVld[g][sel];
                    outM = (cntM > 0) && doutRdy[g];
                    if (inM) begin
                        o.eop  = portQ[g][sel][0].eop;
                        o.src  = SW'(sel);
                        o.data = portQ[g][sel][0].data;
                        expQ[g].push_back(o);
                        if (ownM < 0) ptrM = (sel + 1) % N;
                        ownM = o.eop ? -1 : sel;
                    end
                    cntM = cntM + int'(inM) - int'(outM);
                    act  = dinVld[g] & dinRdy[g];
                end
                @(posedge clk);
                #1;
                if (!rst_n) begin
                    dinVld[g]  = '0;
                    dinEop[g]  = '0;
                    doutRdy[g] = 1'b0;
                end else begin
                    for (int k = 0; k < N; k++) begin
                        if (act[k] && portQ[g][k].size() > 0) void'(portQ[g][k].pop_front());
                        if (!(dinVld[g][k] && !act[k])) begin
                            if (portQ[g][k].size() > 0 && int'($urandom_range(99)) >= gapPct) begin
                                dinVld[g][k]           = 1'b1;
                                din[g][k*DW +: DW]     = portQ[g][k][0].data;
                                dinEop[g][k]           = portQ[g][k][0].eop;
                            end else begin
                                dinVld[g][k] = 1'b0;
                            end
                        end
                    end
                    case (rdyMode)
                        1:       doutRdy[g] = 1'($urandom_range(1));
                        2:       doutRdy[g] = (rdyCyc % 3 == 0);
                        default: doutRdy[g] = 1'b1;
                    endcase
                    rdyCyc++;
                end
            end
        end

        initial begin : monitor
            obeat_t held;
            obeat_t got;
            obeat_t want;
            logic   stalled;
            stalled = 1'b0;
            held    = '0;
            forever begin
                @(negedge clk);
                got = {doutEop[g], doutSrc[g], dout[g]};
                if (!rst_n) begin
                    stalled = 1'b0;
                end else begin
                    if (stalled) checkOutput("hold_stable", g, 64'(got), 64'(held));
                    stalled = 1'b0;
                    if (doutVld[g] && doutRdy[g]) begin
                        checkOutput("sb_pending", g, 64'(expQ[g].size() > 0), 64'd1);
                        if (expQ[g].size() > 0) begin
                            want = expQ[g].pop_front();
                            checkOutput("dout_beat", g, 64'(got), 64'(want));
                        end
                    end else if (doutVld[g]) begin
                        held    = got;
                        stalled = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;

        $display("[TB] all ports, 2-beat packets, full throughput");
        @(negedge clk);
        #2;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < N; k++) applyStimulus(k, 2);
        end
        waitDrain(200);

        $display("[TB] port 2 alone, 3-beat packet");
        @(negedge clk);
        #2;
        applyStimulus(2, 3);
        waitDrain(100);

        $display("[TB] ports 0 and 3 together after port 2 packet");
        @(negedge clk);
        #2;
        applyStimulus(0, 1);
        applyStimulus(3, 1);
        waitDrain(100);

        $display("[TB] back-pressure with late request from port 3");
        rdyMode = 2;
        @(negedge clk);
        #2;
        applyStimulus(1, 4);
        repeat (3) @(negedge clk);
        #2;
        applyStimulus(3, 2);
        waitDrain(200);
        rdyMode = 0;

        $display("[TB] single-beat packets from ports 0 and 3");
        @(negedge clk);
        #2;
        for (int r = 0; r < 4; r++) begin
            applyStimulus(0, 1);
            applyStimulus(3, 1);
        end
        waitDrain(100);

        $display("[TB] reset in the middle of a port 2 packet");
        @(negedge clk);
        #2;
        applyStimulus(2, 5);
        n = 0;
        while (portQ[0][2].size() > 3 && n < 50) begin
            @(posedge clk);
            #2;
            n++;
        end
        checkOutput("mid_pkt_reached", 0, 64'(portQ[0][2].size()), 64'd3);
        #1 rst_n = 1'b0;
        #1;
        for (int g = 0; g < NI; g++) begin
            checkOutput("rst_async_din_rdy", g, 64'(dinRdy[g]), 64'd0);
            checkOutput("rst_async_dout_vld", g, 64'(doutVld[g]), 64'd0);
        end
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        #2;
        applyStimulus(3, 1);
        applyStimulus(0, 1);
        waitDrain(100);

        $display("[TB] randomized traffic with gaps and random back-pressure");
        gapPct  = 25;
        rdyMode = 1;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            #2;
            if ($urandom_range(2) == 0) applyStimulus(int'($urandom_range(N - 1)), int'($urandom_range(4, 1)));
        end
        waitDrain(3000);

        for (int g = 0; g < NI; g++) begin
            checkOutput("sb_empty", g, 64'(expQ[g].size()), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
